// File: rtl/tx_gearbox_param_if.sv
// Upstream word handshake between the TX scrambler and the 64b/66b gearbox.
interface tx_gearbox_param_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic [1:0]            i_header;
  logic                  i_valid;
  logic                  o_ready;

  modport master (output i_data, i_header, i_valid, input o_ready);
  modport slave  (input  i_data, i_header, i_valid, output o_ready);
endinterface

// File: rtl/tx_gearbox_param.sv
// 64b/66b TX gearbox: packs 66-bit blocks into a continuous DATA_WIDTH-bit serialiser
// stream, pausing the scrambler for WPB cycles at the end of every sequence period.
module tx_gearbox_param #(
  parameter  int DATA_WIDTH = 32,
  localparam int WPB        = 64 / DATA_WIDTH,
  localparam int SEQ_LEN    = 33 * WPB,
  localparam int SEQ_W      = $clog2(SEQ_LEN)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  tx_gearbox_param_if.slave     s_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [SEQ_W-1:0]      o_seq,
  output logic                  o_underflow,
  input  logic                  i_clear_err
);

  localparam int BUF_SIZE = DATA_WIDTH + 66;
  localparam int RDY_LIM  = 32 * WPB;
  localparam int CNT_W    = $clog2(BUF_SIZE + 1);
  localparam int WIDX_W   = (WPB > 1) ? $clog2(WPB) : 1;

  if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("tx_gearbox_param: DATA_WIDTH must be 16, 32 or 64");
  end

  logic [SEQ_W-1:0]      r_seq;
  logic [WIDX_W-1:0]     r_widx;
  logic [BUF_SIZE-1:0]   r_acc;
  logic [CNT_W-1:0]      r_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_underflow;

  logic                  w_ready;
  logic                  w_first;
  logic                  w_under;
  logic [DATA_WIDTH-1:0] w_word;
  logic [1:0]            w_hdr;
  logic [BUF_SIZE-1:0]   w_app;
  logic [BUF_SIZE-1:0]   w_acc;
  logic [CNT_W-1:0]      w_len;
  logic [CNT_W-1:0]      w_cnt;

  // Missing upstream words become an idle block (word 0) or zero payload so the line stays legal.
  always_comb begin
    w_ready = !i_reset && (r_seq < SEQ_W'(RDY_LIM));
    w_first = (r_widx == '0);
    w_under = w_ready && !s_in.i_valid;
    w_word  = s_in.i_data;
    w_hdr   = s_in.i_header;
    if (w_under) begin
      w_word = w_first ? DATA_WIDTH'(8'h1E) : '0;
      w_hdr  = 2'b10;
    end
    w_app = '0;
    w_len = '0;
    if (w_ready) begin
      if (w_first) begin
        w_app = BUF_SIZE'({w_word, w_hdr});
        w_len = CNT_W'(DATA_WIDTH + 2);
      end else begin
        w_app = BUF_SIZE'(w_word);
        w_len = CNT_W'(DATA_WIDTH);
      end
    end
    w_acc = r_acc | (w_app << r_pend);
    w_cnt = r_pend + w_len;
  end

  assign s_in.o_ready = w_ready;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_seq        = r_seq;
  assign o_underflow  = r_underflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seq       <= '0;
      r_widx      <= '0;
      r_acc       <= '0;
      r_pend      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_seq <= (r_seq == SEQ_W'(SEQ_LEN - 1)) ? '0 : r_seq + SEQ_W'(1);
      if (w_ready) begin
        r_widx <= (r_widx == WIDX_W'(WPB - 1)) ? '0 : r_widx + WIDX_W'(1);
      end
      r_data  <= w_acc[DATA_WIDTH-1:0];
      r_acc   <= w_acc >> DATA_WIDTH;
      r_pend  <= w_cnt - CNT_W'(DATA_WIDTH);
      r_valid <= 1'b1;
      // A fresh underflow outranks a simultaneous clear so no error is ever lost.
      if (w_under) begin
        r_underflow <= 1'b1;
      end else if (i_clear_err) begin
        r_underflow <= 1'b0;
      end
      assert (w_cnt >= CNT_W'(DATA_WIDTH) && w_cnt <= CNT_W'(BUF_SIZE));
      assert (r_pend <= CNT_W'(64));
    end
  end

endmodule

// File: tb/tb_tx_gearbox_param.sv
// Drives DW=16/32/64 gearboxes side by side against a bit-queue model of the 66b line stream.
module tb_tx_gearbox_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             iReset;
  logic [2:0]       iClearErr;
  logic [2:0][63:0] inData;
  logic [2:0][1:0]  inHdr;
  logic [2:0]       inValid;

  tx_gearbox_param_if #(.DATA_WIDTH(16)) if16 ();
  tx_gearbox_param_if #(.DATA_WIDTH(32)) if32 ();
  tx_gearbox_param_if #(.DATA_WIDTH(64)) if64 ();

  assign if16.i_data   = inData[0][15:0];
  assign if32.i_data   = inData[1][31:0];
  assign if64.i_data   = inData[2];
  assign if16.i_header = inHdr[0];
  assign if32.i_header = inHdr[1];
  assign if64.i_header = inHdr[2];
  assign if16.i_valid  = inValid[0];
  assign if32.i_valid  = inValid[1];
  assign if64.i_valid  = inValid[2];

  logic [15:0] data16;
  logic [31:0] data32;
  logic [63:0] data64;
  logic [7:0]  seq16;
  logic [6:0]  seq32;
  logic [5:0]  seq64;
  logic [2:0]  valid;
  logic [2:0]  uf;

  tx_gearbox_param #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_reset(iReset), .s_in(if16), .o_data(data16), .o_valid(valid[0]),
    .o_seq(seq16), .o_underflow(uf[0]), .i_clear_err(iClearErr[0]));
  tx_gearbox_param #(.DATA_WIDTH(32)) dut32 (
    .i_clk(clk), .i_reset(iReset), .s_in(if32), .o_data(data32), .o_valid(valid[1]),
    .o_seq(seq32), .o_underflow(uf[1]), .i_clear_err(iClearErr[1]));
  tx_gearbox_param #(.DATA_WIDTH(64)) dut64 (
    .i_clk(clk), .i_reset(iReset), .s_in(if64), .o_data(data64), .o_valid(valid[2]),
    .o_seq(seq64), .o_underflow(uf[2]), .i_clear_err(iClearErr[2]));

  logic [2:0][63:0] obsData;
  logic [2:0][63:0] obsSeq;
  logic [2:0]       obsReady;
  assign obsData[0] = {48'b0, data16};
  assign obsData[1] = {32'b0, data32};
  assign obsData[2] = data64;
  assign obsSeq[0]  = {56'b0, seq16};
  assign obsSeq[1]  = {57'b0, seq32};
  assign obsSeq[2]  = {58'b0, seq64};
  assign obsReady   = {if64.o_ready, if32.o_ready, if16.o_ready};

  // Model: line bits waiting to be serialised, plus the period position from the ready rule.
  bit          ring [3][2048];
  int          head [3];
  int          tail [3];
  int          mSeq [3];
  int          mWidx [3];
  bit          mUf [3];
  logic [63:0] eData [3];
  bit          eValid [3];
  int          readyHigh [3];
  bit          haveWord [3];
  logic [63:0] curData [3];
  logic [1:0]  curHdr [3];

  bit       rstReq;
  bit [2:0] dropReq;
  bit [2:0] clrReq;
  int       validPct;
  int       nVec;
  int       nMis;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushBit(input int d, input bit b);
    ring[d][tail[d] % 2048] = b;
    tail[d]++;
  endtask

  task automatic applyStimulus();
    logic [63:0] w;
    logic [1:0]  h;
    bit          rdy;
    int          dw;
    int          wpb;
    iReset    = rstReq;
    iClearErr = clrReq;
    for (int d = 0; d < 3; d++) begin
      dw = 16 << d;
      if (!haveWord[d]) begin
        curData[d]  = {$urandom, $urandom} >> (64 - dw);
        curHdr[d]   = 2'($urandom);
        haveWord[d] = 1'b1;
      end
      inValid[d] = !dropReq[d] && ($urandom_range(99) < validPct);
      inData[d]  = curData[d];
      inHdr[d]   = curHdr[d];
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      dw  = 16 << d;
      wpb = 4 >> d;
      rdy = !rstReq && (mSeq[d] < 32 * wpb);
      checkOutput($sformatf("ready_dw%0d_seq%0d", dw, mSeq[d]), 64'(obsReady[d]), 64'(rdy));
      if (obsReady[d]) readyHigh[d]++;
      if (rstReq) begin
        mSeq[d]   = 0;
        mWidx[d]  = 0;
        mUf[d]    = 1'b0;
        head[d]   = 0;
        tail[d]   = 0;
        eData[d]  = '0;
        eValid[d] = 1'b0;
      end else begin
        if (rdy) begin
          if (inValid[d]) begin
            w = inData[d];
            h = inHdr[d];
            haveWord[d] = 1'b0;
          end else begin
            h = 2'b10;
            w = (mWidx[d] == 0) ? 64'h1E : 64'h0;
          end
          if (mWidx[d] == 0) begin
            pushBit(d, h[0]);
            pushBit(d, h[1]);
          end
          for (int i = 0; i < dw; i++) pushBit(d, w[i]);
          mWidx[d] = (mWidx[d] + 1) % wpb;
        end
        if (rdy && !inValid[d]) mUf[d] = 1'b1;
        else if (clrReq[d]) mUf[d] = 1'b0;
        eData[d] = '0;
        for (int i = 0; i < dw; i++) begin
          eData[d][i] = ring[d][head[d] % 2048];
          head[d]++;
        end
        eValid[d] = 1'b1;
        mSeq[d]   = (mSeq[d] + 1) % (33 * wpb);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      dw = 16 << d;
      checkOutput($sformatf("data_dw%0d", dw), obsData[d], eData[d]);
      checkOutput($sformatf("valid_dw%0d", dw), 64'(valid[d]), 64'(eValid[d]));
      checkOutput($sformatf("seq_dw%0d", dw), obsSeq[d], 64'(mSeq[d]));
      checkOutput($sformatf("underflow_dw%0d", dw), 64'(uf[d]), 64'(mUf[d]));
    end
  endtask

  initial begin
    nVec     = 0;
    nMis     = 0;
    validPct = 100;
    rstReq   = 1'b1;
    dropReq  = '0;
    clrReq   = '0;
    for (int d = 0; d < 3; d++) begin
      head[d] = 0; tail[d] = 0; mSeq[d] = 0; mWidx[d] = 0; mUf[d] = 1'b0;
      readyHigh[d] = 0; haveWord[d] = 1'b0; eData[d] = '0; eValid[d] = 1'b0;
    end
    haveWord[2] = 1'b1;
    curData[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
    curHdr[2]   = 2'b01;

    repeat (3) applyStimulus();
    checkOutput("reset_seq32", obsSeq[1], 64'd0);
    checkOutput("reset_data64", obsData[2], 64'd0);
    checkOutput("reset_valid32", 64'(valid[1]), 64'd0);
    checkOutput("reset_uf16", 64'(uf[0]), 64'd0);

    rstReq = 1'b0;
    applyStimulus();
    checkOutput("first_block_dw64", obsData[2], 64'hFFFF_FFFF_FFFF_FFFD);

    for (int d = 0; d < 3; d++) readyHigh[d] = 0;
    repeat (132) applyStimulus();
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("ready_count_dw%0d", 16 << d), 64'(readyHigh[d]), 64'd128);

    for (int n = 0; n < 200 && obsSeq[1] != 64'd10; n++) applyStimulus();
    checkOutput("wait_seq10", obsSeq[1], 64'd10);
    dropReq[1] = 1'b1;
    applyStimulus();
    dropReq = '0;
    checkOutput("uf_set_seq11", 64'(uf[1]), 64'd1);
    checkOutput("uf_seq11", obsSeq[1], 64'd11);
    repeat (5) applyStimulus();
    checkOutput("uf_sticky", 64'(uf[1]), 64'd1);

    for (int n = 0; n < 200 && obsSeq[1] != 64'd20; n++) applyStimulus();
    checkOutput("wait_seq20", obsSeq[1], 64'd20);
    dropReq[1] = 1'b1;
    clrReq[1]  = 1'b1;
    applyStimulus();
    dropReq = '0;
    checkOutput("uf_set_wins", 64'(uf[1]), 64'd1);
    applyStimulus();
    clrReq = '0;
    checkOutput("uf_cleared", 64'(uf[1]), 64'd0);

    for (int n = 0; n < 200 && obsSeq[1] != 64'd39; n++) applyStimulus();
    checkOutput("wait_seq39", obsSeq[1], 64'd39);
    dropReq[1] = 1'b1;
    applyStimulus();
    dropReq = '0;
    checkOutput("uf_word1", 64'(uf[1]), 64'd1);
    rstReq = 1'b1;
    applyStimulus();
    rstReq = 1'b0;
    checkOutput("midreset_seq32", obsSeq[1], 64'd0);
    checkOutput("midreset_data32", obsData[1], 64'd0);
    checkOutput("midreset_valid32", 64'(valid[1]), 64'd0);
    checkOutput("midreset_uf32", 64'(uf[1]), 64'd0);

    validPct = 90;
    for (int n = 0; n < 4300; n++) begin
      clrReq = ($urandom_range(49) == 0) ? 3'b111 : 3'b000;
      applyStimulus();
    end
    clrReq = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
